// File: rtl/axi_burst_ram.sv
// AXI4 INCR-burst slave backed by a byte-enabled RAM; independent read and write FSMs.
// Optional AXI_BURST_RAM_BOUNDS_EN: out-of-range beats are dropped/zeroed and answered with DECERR.
module axi_burst_ram #(
  parameter int C_AXI_WIDTH      = 64,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_SIZE       = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_AXI_WIDTH-1:0]        s_axi_wdata,
  input  logic [C_AXI_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_AXI_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  localparam int WB    = C_AXI_WIDTH / 8;
  localparam int BOFF  = $clog2(WB);
  localparam int MAW   = $clog2(C_MEM_SIZE);
  localparam int WAW   = MAW - BOFF;
  localparam int DEPTH = C_MEM_SIZE / WB;
`ifdef AXI_BURST_RAM_BOUNDS_EN
  localparam int CW    = C_AXI_ADDR_WIDTH - BOFF;
`else
  localparam int CW    = WAW;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [C_AXI_WIDTH-1:0] r_mem [DEPTH];

  wstate_t                r_wst;
  logic                   r_awready;
  logic                   r_wready;
  logic                   r_bvalid;
  logic [1:0]             r_bresp;
  logic [CW-1:0]          r_waddr;
  logic [7:0]             r_wlen;
  logic [7:0]             r_wbeat;
  logic                   r_werr;
  logic                   r_wdec;

  rstate_t                r_rst;
  logic                   r_arready;
  logic                   r_rvalid;
  logic                   r_rlast;
  logic [1:0]             r_rresp;
  logic [C_AXI_WIDTH-1:0] r_rdata;
  logic [CW-1:0]          r_raddr;
  logic [7:0]             r_rlen;
  logic [7:0]             r_rbeat;

  logic                   w_wfire;
  logic                   w_wlast_exp;
  logic                   w_wl_bad;
  logic                   w_woob;
  logic                   w_wen;
  logic [CW-1:0]          w_rnext_addr;
  logic                   w_roob;
  logic [C_AXI_WIDTH-1:0] w_rword;
  logic                   w_unused_inputs;

  assign w_unused_inputs = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                             s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

  always_comb begin
    w_wfire      = r_wready && s_axi_wvalid;
    w_wlast_exp  = (r_wbeat == r_wlen);
    w_wl_bad     = (s_axi_wlast != w_wlast_exp);
    w_rnext_addr = (r_rst == R_IDLE) ? s_axi_araddr[BOFF +: CW] : r_raddr + CW'(1);
    w_rword      = r_mem[w_rnext_addr[WAW-1:0]];
`ifdef AXI_BURST_RAM_BOUNDS_EN
    w_woob       = |r_waddr[CW-1:WAW];
    w_roob       = |w_rnext_addr[CW-1:WAW];
`else
    w_woob       = 1'b0;
    w_roob       = 1'b0;
`endif
    w_wen        = w_wfire && !w_woob;
  end

  // RAM has no reset; a read in the same edge as a write to that word sees the old value.
  always_ff @(posedge clk) begin
    if (w_wen) begin
      for (int unsigned b = 0; b < WB; b++) begin
        if (s_axi_wstrb[b]) r_mem[r_waddr[WAW-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wst     <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
      r_werr    <= 1'b0;
      r_wdec    <= 1'b0;
    end else begin
      case (r_wst)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (r_awready && s_axi_awvalid) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_waddr   <= s_axi_awaddr[BOFF +: CW];
            r_wlen    <= s_axi_awlen;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
            r_wdec    <= 1'b0;
            r_wst     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wfire) begin
            r_waddr <= r_waddr + CW'(1);
            r_wbeat <= r_wbeat + 8'd1;
            r_werr  <= r_werr | w_wl_bad;
            r_wdec  <= r_wdec | w_woob;
            // The beat count, not wlast, terminates the burst.
            if (w_wlast_exp) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_wdec || w_woob)    ? RESP_DECERR :
                          (r_werr || w_wl_bad)  ? RESP_SLVERR : RESP_OKAY;
              r_wst    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wst     <= W_IDLE;
          end
        end
        default: r_wst <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst     <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
    end else begin
      case (r_rst)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (r_arready && s_axi_arvalid) begin
            r_arready <= 1'b0;
            r_raddr   <= w_rnext_addr;
            r_rlen    <= s_axi_arlen;
            r_rbeat   <= '0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (s_axi_arlen == 8'd0);
            r_rdata   <= w_roob ? '0 : w_rword;
            r_rresp   <= w_roob ? RESP_DECERR : RESP_OKAY;
            r_rst     <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rst     <= R_IDLE;
            end else begin
              r_raddr <= w_rnext_addr;
              r_rbeat <= r_rbeat + 8'd1;
              r_rlast <= (r_rbeat + 8'd1 == r_rlen);
              r_rdata <= w_roob ? '0 : w_rword;
              r_rresp <= w_roob ? RESP_DECERR : RESP_OKAY;
            end
          end
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_ram.sv
// Directed plus randomized bench for axi_burst_ram against a word-array memory model.
module tb_axi_burst_ram;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int MS = 4096;
  localparam int NW = MS / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   s_axi_awaddr = '0;
  logic [7:0]      s_axi_awlen = '0;
  logic [2:0]      s_axi_awsize = 3'd3;
  logic [1:0]      s_axi_awburst = 2'd1;
  logic            s_axi_awvalid = 1'b0;
  logic            s_axi_awready;
  logic [DW-1:0]   s_axi_wdata = '0;
  logic [DW/8-1:0] s_axi_wstrb = '0;
  logic            s_axi_wlast = 1'b0;
  logic            s_axi_wvalid = 1'b0;
  logic            s_axi_wready;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready = 1'b0;
  logic [AW-1:0]   s_axi_araddr = '0;
  logic [7:0]      s_axi_arlen = '0;
  logic [2:0]      s_axi_arsize = 3'd3;
  logic [1:0]      s_axi_arburst = 2'd1;
  logic            s_axi_arvalid = 1'b0;
  logic            s_axi_arready;
  logic [DW-1:0]   s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic            s_axi_rvalid;
  logic            s_axi_rready = 1'b0;

  axi_burst_ram #(.C_AXI_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .C_MEM_SIZE(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] mdl [NW];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr, input int i);
    logic [31:0] w;
    w = (addr >> 3) + 32'(i);
    return int'(w % NW);
  endfunction

  function automatic bit oob(input logic [31:0] addr, input int i);
`ifdef AXI_BURST_RAM_BOUNDS_EN
    logic [31:0] ba;
    ba = ((addr >> 3) + 32'(i)) << 3;
    return ba >= MS;
`else
    return 1'b0;
`endif
  endfunction

  // wlast driven high only on beat wl_beat (use len for a clean burst).
  task automatic axi_write(input logic [31:0] addr, input int len, input int wl_beat, input string tag);
    int n;
    bit dec, mism, wl;
    logic [1:0] er;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 100) begin @(negedge clk); n++; end
    chk({tag, " awready"}, s_axi_awready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    chk({tag, " awready_drop"}, s_axi_awready, 0);
    dec = 0; mism = 0;
    for (int i = 0; i <= len; i++) begin
      wl = (i == wl_beat);
      s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = wl; s_axi_wvalid = 1'b1;
      chk({tag, " wready"}, s_axi_wready, 1);
      if (wl != (i == len)) mism = 1;
      if (oob(addr, i)) dec = 1;
      else for (int b = 0; b < 8; b++)
        if (ws[i][b]) mdl[widx(addr, i)][b*8 +: 8] = wd[i][b*8 +: 8];
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    er = dec ? 2'b11 : (mism ? 2'b10 : 2'b00);
    chk({tag, " wready_drop"}, s_axi_wready, 0);
    chk({tag, " bvalid"}, s_axi_bvalid, 1);
    chk({tag, " bresp"}, s_axi_bresp, er);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk({tag, " bvalid_drop"}, s_axi_bvalid, 0);
    chk({tag, " awready_back"}, s_axi_awready, 1);
  endtask

  // mode 0: rready always 1, 1: pattern 1,0,0 repeating, 2: random
  task automatic axi_read(input logic [31:0] addr, input int len, input int mode, input string tag);
    logic [63:0] ex [256];
    logic [1:0]  er [256];
    int n, beat, k;
    bit rr;
    for (int i = 0; i <= len; i++) begin
      ex[i] = oob(addr, i) ? 64'd0 : mdl[widx(addr, i)];
      er[i] = oob(addr, i) ? 2'b11 : 2'b00;
    end
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 100) begin @(negedge clk); n++; end
    chk({tag, " arready"}, s_axi_arready, 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    chk({tag, " arready_drop"}, s_axi_arready, 0);
    beat = 0; k = 0;
    while (beat <= len && k < 2000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      s_axi_rready = rr;
      chk({tag, " rvalid"}, s_axi_rvalid, 1);
      chk({tag, " rdata"}, s_axi_rdata, ex[beat]);
      chk({tag, " rlast"}, s_axi_rlast, (beat == len));
      chk({tag, " rresp"}, s_axi_rresp, er[beat]);
      if (rr) beat++;
      k++;
      @(negedge clk);
    end
    s_axi_rready = 1'b0;
    chk({tag, " beats"}, 64'(beat), 64'(len + 1));
    if (mode == 0) chk({tag, " cycles"}, 64'(k), 64'(len + 1));
    chk({tag, " rvalid_drop"}, s_axi_rvalid, 0);
    chk({tag, " arready_back"}, s_axi_arready, 1);
  endtask

  initial begin
    int len, beats;
    logic [31:0] a;

    // Reset values
    #23;
    chk("rst awready", s_axi_awready, 0);
    chk("rst wready", s_axi_wready, 0);
    chk("rst bvalid", s_axi_bvalid, 0);
    chk("rst bresp", s_axi_bresp, 0);
    chk("rst arready", s_axi_arready, 0);
    chk("rst rvalid", s_axi_rvalid, 0);
    chk("rst rlast", s_axi_rlast, 0);
    chk("rst rresp", s_axi_rresp, 0);
    chk("rst rdata", s_axi_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel awready_pre", s_axi_awready, 0);
    @(negedge clk);
    chk("rel awready", s_axi_awready, 1);
    chk("rel arready", s_axi_arready, 1);

    // Fill whole RAM so the model is fully defined
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      axi_write(32'(h * 2048), 255, 255, "fill");
    end

    // 16-beat burst at 0x100 with data 0..15
    for (int i = 0; i < 16; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
    axi_write(32'h100, 15, 15, "wr16");
    axi_read(32'h100, 15, 0, "rd16");

    // Partial strobe over prior contents
    wd[0] = 64'h11111111_22222222; ws[0] = 8'hFF;
    axi_write(32'h8, 0, 0, "pre8");
    wd[0] = 64'hAAAAAAAA_BBBBBBBB; ws[0] = 8'h0F;
    axi_write(32'h8, 0, 0, "strb8");
    axi_read(32'h8, 0, 0, "rdstrb");
    chk("strb8 literal", s_axi_rdata, 64'h11111111_BBBBBBBB);

    // Back-pressured read
    axi_read(32'h100, 3, 1, "rdstall");

    // Early wlast -> SLVERR, then a clean burst
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(32'h300, 3, 1, "slverr");
    axi_read(32'h300, 3, 0, "rdslv");
    axi_write(32'h300, 3, 3, "clean");

    // Randomized bursts, random strobes and back-pressure
    for (int t = 0; t < 8; t++) begin
      a = {20'd0, 12'($urandom_range(0, 4095))};
      len = $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
      axi_write(a, len, len, "rndwr");
      axi_read(a, len, 2, "rndrd");
    end

    // Concurrent write and read; read starts one word earlier so each overlap is same-edge
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    fork
      axi_write(32'h400, 7, 7, "cwr");
      axi_read(32'h3F8, 7, 0, "crd");
    join
    axi_read(32'h400, 7, 0, "cpost");

    // Burst across the top of memory: wraps, or DECERR when bounds checking is built in
    for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(32'(MS - 8), 1, 1, "edgewr");
    axi_read(32'(MS - 8), 1, 0, "edgerd");
    axi_read(32'h0, 0, 0, "word0");

    // Reset in the middle of a read
    @(negedge clk);
    s_axi_araddr = 32'h200; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    beats = 0;
    while (beats < 3 && s_axi_rvalid) begin @(negedge clk); beats++; end
    chk("mrst beats", 64'(beats), 3);
    chk("mrst rvalid_pre", s_axi_rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst rvalid", s_axi_rvalid, 0);
    chk("mrst arready", s_axi_arready, 0);
    chk("mrst rlast", s_axi_rlast, 0);
    chk("mrst rdata", s_axi_rdata, 0);
    chk("mrst awready", s_axi_awready, 0);
    s_axi_rready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst arready_back", s_axi_arready, 1);
    chk("mrst rvalid_idle", s_axi_rvalid, 0);
    axi_read(32'h100, 15, 0, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
